// File: rtl/alu_pkg.sv
// Shared constants for the sequential ALU controller: operation codes,
// ALUop classes and the FSM state encoding.
package alu_pkg;

   localparam logic [3:0] OP_AND     = 4'b0000;
   localparam logic [3:0] OP_OR      = 4'b0001;
   localparam logic [3:0] OP_ADD     = 4'b0010;
   localparam logic [3:0] OP_SUB     = 4'b0110;
   localparam logic [3:0] OP_SLT     = 4'b0111;
   localparam logic [3:0] OP_MUL     = 4'b1000;
   localparam logic [3:0] OP_SLL     = 4'b1001;
   localparam logic [3:0] OP_SRL     = 4'b1010;
   localparam logic [3:0] OP_NOR     = 4'b1100;
   localparam logic [3:0] OP_INVALID = 4'b1111;

   localparam logic [1:0] ALUOP_ADD   = 2'b00;
   localparam logic [1:0] ALUOP_SUB   = 2'b01;
   localparam logic [1:0] ALUOP_RTYPE = 2'b10;
   localparam logic [1:0] ALUOP_MTYPE = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_EXEC = 2'b01,
      ST_DONE = 2'b10
   } state_e;

endpackage

// File: rtl/alu_decode.sv
// Combinational decode of ALUop/funct into a 4-bit operation code;
// anything not listed in the operation table decodes to OP_INVALID.
module alu_decode
   import alu_pkg::*;
#(
   parameter int FUNCT_W = 4
) (
   input  logic [1:0]         ALUop,
   input  logic [FUNCT_W-1:0] funct,
   output logic [3:0]         operation,
   output logic               invalid
);

   logic hi_nz;

   // Shifting rather than slicing keeps FUNCT_W == 4 legal (empty upper field).
   assign hi_nz = (funct >> 4) != '0;

   // NOTE: every output gets a default before the case, so no path leaves it unassigned and no latch is inferred.
   always_comb begin
      operation = OP_INVALID;
      case (ALUop)
         ALUOP_ADD: operation = OP_ADD;
         ALUOP_SUB: operation = OP_SUB;
         ALUOP_RTYPE: begin
            if (!hi_nz) begin
               case (funct[3:0])
                  4'b0000: operation = OP_ADD;
                  4'b0010: operation = OP_SUB;
                  4'b0100: operation = OP_AND;
                  4'b0101: operation = OP_OR;
                  4'b0111: operation = OP_NOR;
                  4'b1010: operation = OP_SLT;
                  default: operation = OP_INVALID;
               endcase
            end
         end
         ALUOP_MTYPE: begin
            if (!hi_nz) begin
               case (funct[3:0])
                  4'b0001: operation = OP_MUL;
                  4'b0011: operation = OP_SLL;
                  4'b0110: operation = OP_SRL;
                  default: operation = OP_INVALID;
               endcase
            end
         end
         default: operation = OP_INVALID;
      endcase
   end

   assign invalid = (operation == OP_INVALID);

endmodule

// File: rtl/alu_ctrl_seq.sv
// Sequential ALU with valid/ready handshakes: single-cycle ops finish in one
// cycle, MUL runs a DATA_W-cycle shift-add loop; the result is held until consumed.
module alu_ctrl_seq
   import alu_pkg::*;
#(
   parameter int FUNCT_W = 4,
   parameter int DATA_W  = 32
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [1:0]         ALUop,
   input  logic [FUNCT_W-1:0] funct,
   input  logic [DATA_W-1:0]  a,
   input  logic [DATA_W-1:0]  b,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [3:0]         operation,
   output logic [DATA_W-1:0]  result,
   output logic               zero,
   output logic               err,
   output logic               busy
);

   localparam int CNT_W = $clog2(DATA_W + 1);
   localparam int SH_W  = $clog2(DATA_W);

   state_e              state_q;
   logic [CNT_W-1:0]    cnt_q;
   logic [DATA_W-1:0]   mcand_q;
   logic [DATA_W-1:0]   mplier_q;
   logic [DATA_W-1:0]   acc_q;
   logic [DATA_W-1:0]   result_q;
   logic [3:0]          op_q;
   logic                zero_q;
   logic                err_q;

   logic [3:0]          dec_op;
   logic                dec_invalid;
   logic [DATA_W-1:0]   alu_d;
   logic [DATA_W-1:0]   acc_d;

   alu_decode #(.FUNCT_W(FUNCT_W)) u_decode (
      .ALUop     (ALUop),
      .funct     (funct),
      .operation (dec_op),
      .invalid   (dec_invalid)
   );

   // Single-cycle result straight from the request operands; MUL and INVALID yield 0 here.
   always_comb begin
      alu_d = '0;
      case (dec_op)
         OP_AND: alu_d = a & b;
         OP_OR:  alu_d = a | b;
         OP_ADD: alu_d = a + b;
         OP_SUB: alu_d = a - b;
         OP_SLT: alu_d = DATA_W'($signed(a) < $signed(b));
         OP_SLL: alu_d = a << b[SH_W-1:0];
         OP_SRL: alu_d = a >> b[SH_W-1:0];
         OP_NOR: alu_d = ~(a | b);
         default: alu_d = '0;
      endcase
   end

   assign acc_d = acc_q + (mplier_q[0] ? mcand_q : '0);

   // NOTE: all state below is sequential and uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         mcand_q  <= '0;
         mplier_q <= '0;
         acc_q    <= '0;
         result_q <= '0;
         op_q     <= OP_AND;
         zero_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (in_valid) begin
                  op_q <= dec_op;
                  if (dec_op == OP_MUL) begin
                     mcand_q  <= a;
                     mplier_q <= b;
                     acc_q    <= '0;
                     cnt_q    <= '0;
                     state_q  <= ST_EXEC;
                  end else begin
                     result_q <= alu_d;
                     zero_q   <= (alu_d == '0);
                     err_q    <= dec_invalid;
                     state_q  <= ST_DONE;
                  end
               end
            end
            ST_EXEC: begin
               acc_q    <= acc_d;
               mcand_q  <= mcand_q << 1;
               mplier_q <= mplier_q >> 1;
               cnt_q    <= cnt_q + 1'b1;
               if (cnt_q == CNT_W'(DATA_W - 1)) begin
                  result_q <= acc_d;
                  zero_q   <= (acc_d == '0);
                  err_q    <= 1'b0;
                  state_q  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (out_ready) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign in_ready  = (state_q == ST_IDLE);
   assign busy      = (state_q != ST_IDLE);
   assign out_valid = (state_q == ST_DONE);
   assign operation = op_q;
   assign result    = result_q;
   assign zero      = zero_q;
   assign err       = err_q;

endmodule
